pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Frame-rate motion and game-state controller for the Pong demo.
- Owns puck and paddle positions, bounce and collision decisions, the hit score and the serve/play/game-over sequencing.
- Updates once per video frame on the new-frame strobe.
- Its position outputs drive the puck and paddle block sprites; the renderer merges the sprite colours.

Parameters:
GAME_WIDTH, 1280, active pixels per line
GAME_HEIGHT, 720, active lines per frame
PADDLE_WIDTH, 16, paddle width in px (paddle fixed at x=0)
PADDLE_HEIGHT, 128, paddle height in px
PUCK_WIDTH, 128, puck width in px
PUCK_HEIGHT, 128, puck height in px
PUCK_STEP_SLOW / PUCK_STEP_FAST, 2 / 4, puck px per frame per axis
PADDLE_STEP_SLOW / PADDLE_STEP_FAST, 4 / 8, paddle px per frame
SERVE_FRAMES, 60, frames the puck is held centred before play

Ports:
i_pixel_clk  in  1  pixel clock; single clock domain
i_rst_n  in  1  asynchronous, active-low reset
i_nf  in  1  one-cycle new-frame strobe
i_control  in  2  [1]=up, [0]=down (level)
i_puck_speed  in  1  1 selects PUCK_STEP_FAST
i_paddle_speed  in  1  1 selects PADDLE_STEP_FAST
i_start  in  1  level; restarts the game from OVER
i_serve_seed  in  2  [0]=initial dir_x, [1]=initial dir_y, latched at serve end
o_puck_x  out  11  puck left edge
o_puck_y  out  10  puck top edge
o_paddle_y  out  10  paddle top edge
o_overlap  out  1  puck/paddle rectangles intersect (combinational)
o_game_over  out  1  high in OVER
o_state  out  2  00 SERVE, 01 PLAY, 10 OVER
o_hits  out  8  successful paddle returns, saturating at 255

Behaviour:
- All state is updated only on i_pixel_clk edges where i_nf=1, except the OVER->SERVE restart and reset.
- Outputs reflect an update the cycle after the i_nf strobe. Speed inputs are sampled on the i_nf cycle.
- Reset (i_rst_n=0, asynchronous):
  - puck_x=576, puck_y=296, paddle_y=296
  - dir_x=0, dir_y=0
  - state=SERVE, frame counter=0, hits=0, o_game_over=0
- Paddle (SERVE and PLAY):
  - up only: paddle_y = max(0, paddle_y-pstep)
  - down only: paddle_y = min(GAME_HEIGHT-PADDLE_HEIGHT, paddle_y+pstep)
  - both or neither: no move
  - Compare before subtracting; unsigned values never wrap.
- SERVE:
  - Puck held at centre; counter increments per i_nf.
  - On the i_nf where counter==SERVE_FRAMES-1: go to PLAY, dir_x<=seed[0], dir_y<=seed[1], counter<=0. The puck does not move on that frame.
- PLAY, X axis (s = puck step):
  - dir_x=1: if puck_x+s >= GAME_WIDTH-PUCK_WIDTH then puck_x<=GAME_WIDTH-PUCK_WIDTH and dir_x<=0; else puck_x+=s.
  - dir_x=0 and puck_x > PADDLE_WIDTH+s: puck_x-=s.
  - dir_x=0 and puck_x <= PADDLE_WIDTH+s (reaches the paddle plane), vertical overlap is tested on pre-update positions:
    - Overlap = puck_y < paddle_y+PADDLE_HEIGHT and paddle_y < puck_y+PUCK_HEIGHT.
    - Hit: puck_x<=PADDLE_WIDTH, dir_x<=1, hits+=1 (saturating).
    - Miss: puck_x<=0, state<=OVER.
- PLAY, Y axis (same frame, independent of X):
  - Reflect at 0 and at GAME_HEIGHT-PUCK_HEIGHT with clamp, mirroring the X rule.
  - Y still updates on the miss frame.
- OVER:
  - Puck and paddle frozen; o_game_over=1.
  - i_start=1 on any cycle: state<=SERVE, puck recentred, counter=0, hits=0, dir cleared.
  - i_start has priority over a coincident i_nf; no motion occurs that cycle.
- o_overlap = (o_puck_x < PADDLE_WIDTH) and the vertical overlap term, from current registered positions. Valid in all states.
- o_state is encoded directly from the state register. The unused encoding 11 recovers to SERVE on the next clock.
- Reset asserted mid-frame takes effect immediately; the first i_nf after release starts serve counting.

Test Plan:
- Reset, then 60 i_nf pulses with seed=2'b11 -> o_state 00 for 59 frames, 01 after the 60th; puck stays at (576,296); the first PLAY frame with speed=0 gives (578,298).
- PLAY, dir_x=1, puck_x=1150, i_puck_speed=1 -> puck_x=1152 and dir_x=0; the next frame gives 1148.
- Paddle at y=0, i_control=2'b10, i_paddle_speed=1 -> paddle_y stays 0; i_control=2'b11 from y=296 -> 296 unchanged.
- Puck moving left at x=18, s=2, paddle_y=puck_y=296 -> puck_x=16, dir_x=1, o_hits 0->1; o_overlap=0 that frame.
- Same approach with paddle_y=0 and puck_y=500 -> puck_x=0, o_game_over=1, o_state=10; further i_nf pulses change nothing; i_start -> o_state=00, o_hits=0, puck at (576,296).
- o_hits preset to 255 and another hit -> stays 255; i_rst_n pulsed low mid-PLAY between clock edges -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame puck/paddle motion, collision, scoring and serve/play/over sequencing
module pong_game_ctrl #(
  parameter int GAME_WIDTH       = 1280,
  parameter int GAME_HEIGHT      = 720,
  parameter int PADDLE_WIDTH     = 16,
  parameter int PADDLE_HEIGHT    = 128,
  parameter int PUCK_WIDTH       = 128,
  parameter int PUCK_HEIGHT      = 128,
  parameter int PUCK_STEP_SLOW   = 2,
  parameter int PUCK_STEP_FAST   = 4,
  parameter int PADDLE_STEP_SLOW = 4,
  parameter int PADDLE_STEP_FAST = 8,
  parameter int SERVE_FRAMES     = 60
) (
  input  logic        i_pixel_clk,
  input  logic        i_rst_n,
  input  logic        i_nf,
  input  logic [1:0]  i_control,
  input  logic        i_puck_speed,
  input  logic        i_paddle_speed,
  input  logic        i_start,
  input  logic [1:0]  i_serve_seed,
  output logic [10:0] o_puck_x,
  output logic [9:0]  o_puck_y,
  output logic [9:0]  o_paddle_y,
  output logic        o_overlap,
  output logic        o_game_over,
  output logic [1:0]  o_state,
  output logic [7:0]  o_hits
);
  localparam int CW = $clog2(SERVE_FRAMES);
  localparam logic [11:0] X_MAX = 12'(GAME_WIDTH - PUCK_WIDTH);
  localparam logic [11:0] Y_MAX = 12'(GAME_HEIGHT - PUCK_HEIGHT);
  localparam logic [11:0] P_MAX = 12'(GAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic [11:0] X_MIN = 12'(PADDLE_WIDTH);
  localparam logic [10:0] X_C = 11'((GAME_WIDTH - PUCK_WIDTH) / 2);
  localparam logic [9:0] Y_C = 10'((GAME_HEIGHT - PUCK_HEIGHT) / 2);
  localparam logic [9:0] P_C = 10'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);
  typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  state_t state, nx_state;
  logic [10:0] puck_x, nx_x;
  logic [9:0] puck_y, nx_y, paddle_y, nx_pad;
  logic dir_x, dir_y, nx_dx, nx_dy;
  logic [CW-1:0] cnt, nx_cnt;
  logic [7:0] hits, nx_hits;
  logic [11:0] wx, wy, wp, ps, pd;
  logic v_ov;
  // Widened copies so step arithmetic and bound compares never wrap
  assign wx = {1'b0, puck_x};
  assign wy = {2'b0, puck_y};
  assign wp = {2'b0, paddle_y};
  assign ps = i_puck_speed ? 12'(PUCK_STEP_FAST) : 12'(PUCK_STEP_SLOW);
  assign pd = i_paddle_speed ? 12'(PADDLE_STEP_FAST) : 12'(PADDLE_STEP_SLOW);
  assign v_ov = (wy < wp + 12'(PADDLE_HEIGHT)) && (wp < wy + 12'(PUCK_HEIGHT));
  assign o_overlap = (wx < X_MIN) && v_ov;
  assign o_puck_x = puck_x;
  assign o_puck_y = puck_y;
  assign o_paddle_y = paddle_y;
  assign o_hits = hits;
  assign o_state = state;
  assign o_game_over = state == OVER;
  // Next-state logic: restart from OVER is immediate, everything else moves only on the frame strobe
  always_comb begin
    nx_state = state;
    nx_x = puck_x;
    nx_y = puck_y;
    nx_pad = paddle_y;
    nx_dx = dir_x;
    nx_dy = dir_y;
    nx_cnt = cnt;
    nx_hits = hits;
    if (state == OVER) begin
      if (i_start) begin
        nx_state = SERVE;
        nx_x = X_C;
        nx_y = Y_C;
        nx_dx = 1'b0;
        nx_dy = 1'b0;
        nx_cnt = '0;
        nx_hits = '0;
      end
    end else if (state != SERVE && state != PLAY) begin
      nx_state = SERVE;
    end else if (i_nf) begin
      if (i_control == 2'b10) nx_pad = wp > pd ? 10'(wp - pd) : 10'd0;
      if (i_control == 2'b01) nx_pad = wp + pd >= P_MAX ? P_MAX[9:0] : 10'(wp + pd);
      if (state == SERVE) begin
        nx_cnt = cnt == CW'(SERVE_FRAMES - 1) ? '0 : cnt + 1'b1;
        if (cnt == CW'(SERVE_FRAMES - 1)) begin
          nx_state = PLAY;
          nx_dx = i_serve_seed[0];
          nx_dy = i_serve_seed[1];
        end
      end else begin
        if (dir_x) begin
          nx_dx = wx + ps < X_MAX;
          nx_x = wx + ps >= X_MAX ? X_MAX[10:0] : 11'(wx + ps);
        end else if (wx > X_MIN + ps) begin
          nx_x = 11'(wx - ps);
        end else if (v_ov) begin
          nx_x = X_MIN[10:0];
          nx_dx = 1'b1;
          nx_hits = hits + {7'd0, hits != 8'hff};
        end else begin
          nx_x = '0;
          nx_state = OVER;
        end
        if (dir_y) begin
          nx_dy = wy + ps < Y_MAX;
          nx_y = wy + ps >= Y_MAX ? Y_MAX[9:0] : 10'(wy + ps);
        end else begin
          nx_dy = wy <= ps;
          nx_y = wy > ps ? 10'(wy - ps) : 10'd0;
        end
      end
    end
  end
  // State register with asynchronous reset to the centred serve position
  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= SERVE;
      puck_x <= X_C;
      puck_y <= Y_C;
      paddle_y <= P_C;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      cnt <= '0;
      hits <= '0;
    end else begin
      state <= nx_state;
      puck_x <= nx_x;
      puck_y <= nx_y;
      paddle_y <= nx_pad;
      dir_x <= nx_dx;
      dir_y <= nx_dy;
      cnt <= nx_cnt;
      hits <= nx_hits;
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: vector table plus frame-level scoreboard against a behavioural Pong model
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic rst_n, nf, puck_speed, paddle_speed, start;
  logic [1:0] control, seed;
  logic [10:0] o_puck_x;
  logic [9:0] o_puck_y, o_paddle_y;
  logic o_overlap, o_game_over;
  logic [1:0] o_state;
  logic [7:0] o_hits;
  logic nf2;
  logic [10:0] s_x;
  logic [9:0] s_y, s_pad;
  logic s_ov, s_go;
  logic [1:0] s_state;
  logic [7:0] s_hits;
  int n_pass = 0, n_total = 0;
  int mx, my, mp, mdx, mdy, mst, mcnt, mh;
  typedef struct {int st; int x; int y; int p; int h; int go; int ov;} exp_t;
  typedef struct {int reps; logic [1:0] c; bit pf; bit df; int st; int x; int y; int p; int h;} vec_t;
  exp_t sb[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  pong_game_ctrl u_dut (
    .i_pixel_clk(clk), .i_rst_n(rst_n), .i_nf(nf), .i_control(control),
    .i_puck_speed(puck_speed), .i_paddle_speed(paddle_speed), .i_start(start),
    .i_serve_seed(seed), .o_puck_x(o_puck_x), .o_puck_y(o_puck_y),
    .o_paddle_y(o_paddle_y), .o_overlap(o_overlap), .o_game_over(o_game_over),
    .o_state(o_state), .o_hits(o_hits)
  );

  // Narrow arena: the puck can never miss, so the score climbs quickly to saturation
  pong_game_ctrl #(.GAME_WIDTH(300), .GAME_HEIGHT(128)) u_small (
    .i_pixel_clk(clk), .i_rst_n(rst_n), .i_nf(nf2), .i_control(2'b00),
    .i_puck_speed(1'b1), .i_paddle_speed(1'b0), .i_start(1'b0),
    .i_serve_seed(2'b01), .o_puck_x(s_x), .o_puck_y(s_y),
    .o_paddle_y(s_pad), .o_overlap(s_ov), .o_game_over(s_go),
    .o_state(s_state), .o_hits(s_hits)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // y and direction packed as y*2+dir so one function both steps and predicts
  function automatic int ystep(input int yd, input int s);
    int y = yd / 2;
    if (yd % 2 == 1) return (y + s >= 592) ? 592 * 2 : (y + s) * 2 + 1;
    return (y > s) ? (y - s) * 2 : 1;
  endfunction

  function automatic int pred(input int y, input int d, input int n);
    int yd = y * 2 + d;
    for (int k = 0; k < n; k++) yd = ystep(yd, 2);
    return yd / 2;
  endfunction

  task automatic m_reset();
    mx = 576; my = 296; mp = 296; mdx = 0; mdy = 0; mst = 0; mcnt = 0; mh = 0;
  endtask

  task automatic m_frame(input logic [1:0] c, input bit pf, input bit df, input bit st);
    int s = pf ? 4 : 2;
    int t = df ? 8 : 4;
    bit vert = (my < mp + 128) && (mp < my + 128);
    int yd;
    if (mst == 2) begin
      if (st) begin mst = 0; mx = 576; my = 296; mcnt = 0; mh = 0; mdx = 0; mdy = 0; end
      return;
    end
    if (c == 2'b10) mp = (mp < t) ? 0 : mp - t;
    else if (c == 2'b01) mp = (mp + t > 592) ? 592 : mp + t;
    if (mst == 0) begin
      if (mcnt == 59) begin mst = 1; mdx = int'(seed[0]); mdy = int'(seed[1]); mcnt = 0; end
      else mcnt++;
      return;
    end
    if (mdx == 1) begin
      if (mx + s >= 1152) begin mx = 1152; mdx = 0; end
      else mx += s;
    end else if (mx > 16 + s) mx -= s;
    else if (vert) begin mx = 16; mdx = 1; if (mh < 255) mh++; end
    else begin mx = 0; mst = 2; end
    yd = ystep(my * 2 + mdy, s);
    my = yd / 2;
    mdy = yd % 2;
  endtask

  task automatic frame(input logic [1:0] c, input bit pf, input bit df, input bit st);
    exp_t e;
    @(negedge clk);
    control = c; puck_speed = pf; paddle_speed = df; start = st; nf = 1'b1;
    m_frame(c, pf, df, st);
    sb.push_back('{mst, mx, my, mp, mh, int'(mst == 2),
                   int'(mx < 16 && my < mp + 128 && mp < my + 128)});
    @(posedge clk);
    #1 nf = 1'b0; start = 1'b0;
    e = sb.pop_front();
    chk("sb_state", int'(o_state), e.st);
    chk("sb_puck_x", int'(o_puck_x), e.x);
    chk("sb_puck_y", int'(o_puck_y), e.y);
    chk("sb_paddle_y", int'(o_paddle_y), e.p);
    chk("sb_hits", int'(o_hits), e.h);
    chk("sb_game_over", int'(o_game_over), e.go);
    chk("sb_overlap", int'(o_overlap), e.ov);
  endtask

  function automatic logic [1:0] steer(input int t);
    return (mp + 8 <= t) ? 2'b01 : ((mp >= t + 8) ? 2'b10 : 2'b00);
  endfunction

  initial begin
    int n;
    tbl[0] = '{59, 2'b00, 0, 0, 0, 576, 296, 296, 0};
    tbl[1] = '{1,  2'b00, 0, 0, 1, 576, 296, 296, 0};
    tbl[2] = '{1,  2'b00, 0, 0, 1, 578, 298, 296, 0};
    tbl[3] = '{37, 2'b10, 0, 1, 1, 652, 372, 0,   0};
    tbl[4] = '{1,  2'b10, 0, 1, 1, 654, 374, 0,   0};
    tbl[5] = '{1,  2'b11, 0, 1, 1, 656, 376, 0,   0};
    tbl[6] = '{37, 2'b01, 0, 1, 1, 730, 450, 296, 0};
    tbl[7] = '{1,  2'b11, 0, 1, 1, 732, 452, 296, 0};
    tbl[8] = '{1,  2'b01, 0, 0, 1, 734, 454, 300, 0};
    rst_n = 1'b0; nf = 1'b0; nf2 = 1'b0; control = 2'b00; puck_speed = 1'b0;
    paddle_speed = 1'b0; start = 1'b0; seed = 2'b11;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_state", int'(o_state), 0);
    chk("rst_puck_x", int'(o_puck_x), 576);
    chk("rst_puck_y", int'(o_puck_y), 296);
    chk("rst_paddle_y", int'(o_paddle_y), 296);
    chk("rst_hits", int'(o_hits), 0);
    chk("rst_game_over", int'(o_game_over), 0);
    chk("rst_overlap", int'(o_overlap), 0);

    nf2 = 1'b1;
    repeat (25000) @(posedge clk);
    @(negedge clk) nf2 = 1'b0;
    chk("sat_hits", int'(s_hits), 255);
    chk("sat_state", int'(s_state), 1);
    chk("sat_game_over", int'(s_go), 0);
    chk("sat_puck_y", int'(s_y), 0);
    chk("sat_paddle_y", int'(s_pad), 0);
    chk("sat_x_bound", int'(s_x <= 11'd172), 1);
    chk("sat_overlap", int'(s_ov), int'(s_x < 11'd16));

    for (int i = 0; i < 9; i++) begin
      repeat (tbl[i].reps) frame(tbl[i].c, tbl[i].pf, tbl[i].df, 1'b0);
      chk($sformatf("tbl%0d_state", i), int'(o_state), tbl[i].st);
      chk($sformatf("tbl%0d_puck_x", i), int'(o_puck_x), tbl[i].x);
      chk($sformatf("tbl%0d_puck_y", i), int'(o_puck_y), tbl[i].y);
      chk($sformatf("tbl%0d_paddle_y", i), int'(o_paddle_y), tbl[i].p);
      chk($sformatf("tbl%0d_hits", i), int'(o_hits), tbl[i].h);
    end

    repeat (208) frame(2'b00, 0, 0, 0);
    chk("right_pre_x", int'(o_puck_x), 1150);
    frame(2'b00, 1, 0, 0);
    chk("right_clamp_x", int'(o_puck_x), 1152);
    frame(2'b00, 1, 0, 0);
    chk("right_return_x", int'(o_puck_x), 1148);

    for (int i = 0; i < 2000 && mh == 0 && mst == 1; i++) begin
      n = (mx - 18) / 2;
      frame(steer(pred(my, mdy, n)), 0, 1, 0);
    end
    chk("hit_puck_x", int'(o_puck_x), 16);
    chk("hit_hits", int'(o_hits), 1);
    chk("hit_overlap", int'(o_overlap), 0);
    chk("hit_state", int'(o_state), 1);

    for (int i = 0; i < 3000 && mst == 1; i++) begin
      n = (mdx == 1) ? (1152 - mx) / 2 + 567 : (mx - 18) / 2;
      frame(steer(pred(my, mdy, n) >= 296 ? 0 : 592), 0, 1, 0);
    end
    chk("miss_state", int'(o_state), 2);
    chk("miss_game_over", int'(o_game_over), 1);
    chk("miss_puck_x", int'(o_puck_x), 0);
    chk("miss_hits", int'(o_hits), 1);

    repeat (5) frame(2'b01, 1, 1, 0);
    frame(2'b01, 1, 1, 1);
    chk("restart_state", int'(o_state), 0);
    chk("restart_puck_x", int'(o_puck_x), 576);
    chk("restart_puck_y", int'(o_puck_y), 296);
    chk("restart_hits", int'(o_hits), 0);
    chk("restart_game_over", int'(o_game_over), 0);

    seed = 2'b01;
    repeat (63) frame(2'b10, 0, 0, 0);
    chk("pre_rst_state", int'(o_state), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_rst_state", int'(o_state), mst);
    chk("async_rst_puck_x", int'(o_puck_x), 576);
    chk("async_rst_puck_y", int'(o_puck_y), 296);
    chk("async_rst_paddle_y", int'(o_paddle_y), 296);
    chk("async_rst_hits", int'(o_hits), 0);
    chk("async_rst_game_over", int'(o_game_over), 0);
    @(negedge clk) rst_n = 1'b1;
    frame(2'b00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
